// File: rtl/uart_rx_tx_fifo.sv
// rtl/uart_rx_tx_fifo.sv - byte FIFO between UART receiver and transmitter in the loopback path
//
// Purpose: buffers received bytes in a circular FIFO and issues one transmit
// request per byte whenever the transmitter is idle. This prevents bytes from
// being lost while the transmitter is busy.
//
// Optional feature macro: UART_FIFO_RTS_EN (adds the registered o_RTS_L flow-control output)
//
// Ports:
//   i_Clk        system clock
//   i_Rst_L      asynchronous active-low reset, synchronous release
//   i_RX_DV      one-cycle pulse: i_RX_Byte is valid
//   i_RX_Byte    received byte
//   i_TX_Active  transmitter busy flag
//   i_TX_Done    one-cycle pulse at the end of the transmitter stop bit
//   o_TX_DV      one-cycle transmit request (registered)
//   o_TX_Byte    byte to transmit, held after o_TX_DV
//   o_Count      fill level, 0..DEPTH
//   o_Empty      o_Count == 0
//   o_Full       o_Count == DEPTH
//   o_Overflow   sticky: a byte was dropped because the FIFO was full
//   o_RTS_L      (UART_FIFO_RTS_EN only) 1 = ask the sender to stop
//   o_Last_Byte  most recently accepted byte, for the display path

module uart_rx_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_MARGIN = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_TX_Active,
    input  logic                  i_TX_Done,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Empty,
    output logic                  o_Full,
    output logic                  o_Overflow,
`ifdef UART_FIFO_RTS_EN
    output logic                  o_RTS_L,
`endif
    output logic [7:0]            o_Last_Byte
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   C_DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = (DEPTH_LOG2)'(1);

    // A margin larger than the FIFO makes the flow-control threshold meaningless.
    if (RTS_MARGIN < 0 || RTS_MARGIN > DEPTH) begin : g_bad_margin
        $error("RTS_MARGIN must lie in 0..DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_pop;
    logic                  w_push;

    logic [7:0]            r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_tx_dv;
    logic [7:0]            r_tx_byte;
    logic                  r_overflow;
    logic [7:0]            r_last_byte;

    assign o_Empty = (r_count == '0);
    assign o_Full  = (r_count == C_DEPTH);

    // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
    // The read of mem[rd_ptr] sees the old contents, so the slot is reused safely.
    assign w_push = i_RX_DV && (!o_Full || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!o_Empty && !i_TX_Active) begin
                    w_pop       = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (i_TX_Done) begin
                    w_state_nxt = GAP;
                end
            end
            // One settle cycle so the transmitter's done/active flags are stable
            // before the next launch decision.
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_overflow  <= 1'b0;
            r_last_byte <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_tx_dv <= w_pop;

            if (w_pop) begin
                r_tx_byte <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
            end

            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + C_PTR_ONE;
                r_last_byte <= i_RX_Byte;
            end else if (i_RX_DV) begin
                r_overflow <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; its contents are only read behind a non-zero count.
    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_RX_Byte;
        end
    end

`ifdef UART_FIFO_RTS_EN
    localparam logic [DEPTH_LOG2:0] C_RTS_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH - RTS_MARGIN);

    logic r_rts_l;

    // Decoded from the registered count, so it trails the count change by one cycle.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_rts_l <= 1'b0;
        end else begin
            r_rts_l <= (r_count >= C_RTS_LEVEL);
        end
    end

    assign o_RTS_L = r_rts_l;
`endif

    assign o_TX_DV     = r_tx_dv;
    assign o_TX_Byte   = r_tx_byte;
    assign o_Count     = r_count;
    assign o_Overflow  = r_overflow;
    assign o_Last_Byte = r_last_byte;

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// tb/tb_uart_rx_tx_fifo.sv - self-checking bench for uart_rx_tx_fifo

module tb_uart_rx_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       i_TX_Active;
    logic       i_TX_Done;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic [4:0] o_Count;
    logic       o_Empty;
    logic       o_Full;
    logic       o_Overflow;
    logic [7:0] o_Last_Byte;
`ifdef UART_FIFO_RTS_EN
    logic       o_RTS_L;
`endif

    logic       stall;
    logic       m_active;
    logic       m_done;
    int         tx_cycles;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         done_edge = 0;
    int         last_dv_edge = 0;
    int         launches = 0;
    int         peak = 0;
    logic       prev_dv = 1'b0;
    logic [7:0] exp_q [$];

    assign i_TX_Active = m_active | stall;
    assign i_TX_Done   = m_done;

    uart_rx_tx_fifo #(.DEPTH_LOG2(4), .RTS_MARGIN(4)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .i_TX_Active (i_TX_Active),
        .i_TX_Done   (i_TX_Done),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .o_Count     (o_Count),
        .o_Empty     (o_Empty),
        .o_Full      (o_Full),
        .o_Overflow  (o_Overflow),
`ifdef UART_FIFO_RTS_EN
        .o_RTS_L     (o_RTS_L),
`endif
        .o_Last_Byte (o_Last_Byte)
    );

    always #42 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Transmitter model: busy for tx_cycles after each request, then a done pulse.
    initial begin
        m_active = 1'b0;
        m_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (o_TX_DV && rst_n) begin
                m_active = 1'b1;
                repeat (tx_cycles) @(negedge clk);
                m_active  = 1'b0;
                m_done    = 1'b1;
                done_edge = cyc + 1;
                @(negedge clk);
                m_done = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard pop on every launch, DV width and done-to-DV spacing.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_dv_edge = cyc;
            peak         = 0;
            prev_dv      = 1'b0;
        end else begin
            if (o_TX_DV) begin
                check("dv_width", prev_dv, 0);
                check("queue_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("tx_byte", o_TX_Byte, exp_q.pop_front());
                if (done_edge > last_dv_edge) check("done_to_dv", cyc - done_edge, 2);
                last_dv_edge = cyc;
                launches++;
            end
            prev_dv = o_TX_DV;
            if (int'(o_Count) > peak) peak = int'(o_Count);
        end
    end

    task automatic push(input logic [7:0] b, input bit acc);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        if (acc) exp_q.push_back(b);
        @(negedge clk);
        i_RX_DV = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_active && !m_done && !o_TX_DV) break;
        end
        check({"drain_", tag}, exp_q.size(), 0);
    endtask

    int l0;

    initial begin
        rst_n     = 1'b0;
        i_RX_DV   = 1'b0;
        i_RX_Byte = 8'h00;
        stall     = 1'b0;
        tx_cycles = 20;

        #1;
        check("rst_dv", o_TX_DV, 0);
        check("rst_byte", o_TX_Byte, 0);
        check("rst_count", o_Count, 0);
        check("rst_empty", o_Empty, 1);
        check("rst_full", o_Full, 0);
        check("rst_ovf", o_Overflow, 0);
        check("rst_last", o_Last_Byte, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte: DV appears after the edge following the write edge.
        push(8'hA5, 1);
        check("single_dv_early", o_TX_DV, 0);
        check("single_count", o_Count, 1);
        check("single_last", o_Last_Byte, 8'hA5);
        @(negedge clk);
        check("single_dv", o_TX_DV, 1);
        check("single_byte", o_TX_Byte, 8'hA5);
        check("single_count0", o_Count, 0);
        @(negedge clk);
        check("single_dv_off", o_TX_DV, 0);
        wait_drain("single", 200);

        // Burst of five with a slow transmitter.
        do_reset();
        tx_cycles = 1070;
        l0 = launches;
        for (int i = 1; i <= 5; i++) push(8'(i), 1);
        wait_drain("burst", 8000);
        check("burst_launches", launches - l0, 5);
        check("burst_peak", peak, 4);

        // Overflow: 17 pushes into a stalled FIFO.
        do_reset();
        tx_cycles = 20;
        stall = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i), 1);
        check("ovf_full", o_Full, 1);
        check("ovf_count16", o_Count, 16);
        check("ovf_not_yet", o_Overflow, 0);
        push(8'h99, 0);
        check("ovf_flag", o_Overflow, 1);
        check("ovf_count", o_Count, 16);
        check("ovf_last", o_Last_Byte, 8'h1F);
        stall = 1'b0;
        wait_drain("ovf", 2000);
        check("ovf_sticky", o_Overflow, 1);
        check("ovf_empty", o_Empty, 1);

        // Full FIFO with a push on the same edge as the pop.
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1);
        stall = 1'b0;
        push(8'h3C, 1);
        check("fp_count", o_Count, 16);
        check("fp_ovf", o_Overflow, 0);
        check("fp_dv", o_TX_DV, 1);
        check("fp_last", o_Last_Byte, 8'h3C);
        wait_drain("fp", 2000);
        check("fp_ovf_end", o_Overflow, 0);

        // Asynchronous reset while a transfer is in flight.
        do_reset();
        tx_cycles = 200;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 1);
        repeat (3) @(negedge clk);
        #5 rst_n = 1'b0;
        #2;
        check("mid_dv", o_TX_DV, 0);
        check("mid_byte", o_TX_Byte, 0);
        check("mid_count", o_Count, 0);
        check("mid_empty", o_Empty, 1);
        check("mid_full", o_Full, 0);
        check("mid_last", o_Last_Byte, 0);
        exp_q.delete();
        #2 rst_n = 1'b1;
        l0 = launches;
        repeat (250) @(negedge clk);
        check("mid_no_launch", launches - l0, 0);
        check("mid_count_end", o_Count, 0);

`ifdef UART_FIFO_RTS_EN
        // Flow control threshold at 12 of 16.
        do_reset();
        tx_cycles = 20;
        stall = 1'b1;
        for (int i = 0; i < 11; i++) push(8'h80 + 8'(i), 1);
        check("rts_low11", o_RTS_L, 0);
        push(8'h8B, 1);
        check("rts_count12", o_Count, 12);
        check("rts_lag", o_RTS_L, 0);
        @(negedge clk);
        check("rts_high", o_RTS_L, 1);
        stall = 1'b0;
        @(negedge clk);
        check("rts_count11", o_Count, 11);
        check("rts_still_high", o_RTS_L, 1);
        @(negedge clk);
        check("rts_fall", o_RTS_L, 0);
        wait_drain("rts", 2000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
